// File: rtl/med_ctrl.sv
// med_ctrl -- sequencer and stream adapter for the MED median-filter core.
//
// Collects a window of SIZE pixels from a valid/ready input stream into a
// local buffer, replays it into MED over SIZE contiguous cycles (DSI high),
// then drives the BYP sort sequence (H passes of SIZE cycles, each ending
// with a BYP cycle that discards the current maximum), waits H FINAL cycles
// and captures MED_DO into a valid/ready output register.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   PI, PI_VALID/READY   input pixel stream
//   PO, PO_VALID/READY   median output stream (registered)
//   MED_DI/DSI/BYP       drive to the MED core (combinational decode)
//   MED_DO               median/data output of the MED core
//   BUSY                 high whenever the sequencer is not idle
module med_ctrl #(
  parameter int SIZE  = 9,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] PI,
  input  logic             PI_VALID,
  output logic             PI_READY,
  output logic [WIDTH-1:0] PO,
  output logic             PO_VALID,
  input  logic             PO_READY,
  output logic [WIDTH-1:0] MED_DI,
  output logic             MED_DSI,
  output logic             MED_BYP,
  input  logic [WIDTH-1:0] MED_DO,
  output logic             BUSY
);

  localparam int H   = (SIZE - 1) / 2;
  localparam int CW  = $clog2(SIZE);
  localparam int WCW = $clog2(SIZE + 1);
  localparam int PW  = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SORT,
    S_FINAL,
    S_CAPT
  } state_t;

  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;     // cycle within LOAD / SORT pass
  logic [PW-1:0]    r_pass, w_pass_nx;   // SORT pass
  logic [PW-1:0]    r_fcnt, w_fcnt_nx;   // FINAL cycle
  logic [WCW-1:0]   r_wcnt;              // buffer fill count
  logic [WIDTH-1:0] r_buf [SIZE];
  logic [WIDTH-1:0] r_po;
  logic             r_po_valid;

  logic w_full, w_acc, w_last_cyc, w_last_pass, w_last_fin;

  assign w_full      = (r_wcnt == WCW'(SIZE));
  assign w_last_cyc  = (r_cnt == CW'(SIZE - 1));
  assign w_last_pass = (r_pass == PW'(H - 1));
  assign w_last_fin  = (r_fcnt == PW'(H - 1));

  // The buffer is being read during LOAD, so filling is held off until the
  // last LOAD cycle frees it; the next window then fills during SORT..CAPT.
  assign PI_READY = !w_full && (r_state != S_LOAD);
  assign w_acc    = PI_VALID && PI_READY;

  assign PO       = r_po;
  assign PO_VALID = r_po_valid;
  assign BUSY     = (r_state != S_IDLE);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pass_nx  = r_pass;
    w_fcnt_nx  = r_fcnt;
    MED_DSI    = 1'b0;
    MED_BYP    = 1'b1;
    MED_DI     = '0;
    case (r_state)
      S_IDLE: begin
        // Only start once the previous median has left, so CAPT can never
        // overwrite a pending PO.
        if (w_full && !r_po_valid) w_state_nx = S_LOAD;
      end
      S_LOAD: begin
        MED_DSI = 1'b1;
        MED_DI  = r_buf[r_cnt];
        if (w_last_cyc) w_state_nx = S_SORT;
        else            w_cnt_nx   = r_cnt + 1'b1;
      end
      S_SORT: begin
        // Last cycle of each pass bypasses, dropping the current maximum.
        MED_BYP = w_last_cyc;
        if (w_last_cyc) begin
          w_cnt_nx = '0;
          if (w_last_pass) w_state_nx = S_FINAL;
          else             w_pass_nx  = r_pass + 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_FINAL: begin
        MED_BYP = 1'b0;
        if (w_last_fin) w_state_nx = S_CAPT;
        else            w_fcnt_nx  = r_fcnt + 1'b1;
      end
      S_CAPT: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
    // Every state starts with all counters at zero.
    if (w_state_nx != r_state) begin
      w_cnt_nx  = '0;
      w_pass_nx = '0;
      w_fcnt_nx = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pass     <= '0;
      r_fcnt     <= '0;
      r_wcnt     <= '0;
      r_po       <= '0;
      r_po_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_pass  <= w_pass_nx;
      r_fcnt  <= w_fcnt_nx;

      if (r_state == S_LOAD && w_last_cyc) r_wcnt <= '0;
      else if (w_acc)                      r_wcnt <= r_wcnt + 1'b1;

      if (r_state == S_CAPT) begin
        r_po       <= MED_DO;
        r_po_valid <= 1'b1;
      end else if (r_po_valid && PO_READY) begin
        r_po_valid <= 1'b0;
      end
    end
  end

  // Pixel storage needs no reset: entries are only read after being written.
  always_ff @(posedge CLK) begin
    if (w_acc) r_buf[r_wcnt] <= PI;
  end

endmodule

// File: tb/tb_med_ctrl.sv
// Self-checking bench for med_ctrl. A small behavioural MED stand-in keeps the
// window as a list: DSI cycles append, a BYP cycle that closes a full pass of
// SIZE-1 compare cycles removes the maximum, and DO is the maximum of what is
// left (the median after H removals). Expected medians come from sorting each
// accepted window.
module tb_med_ctrl;
  localparam int SIZE  = 9;
  localparam int WIDTH = 8;
  localparam int H     = (SIZE - 1) / 2;
  localparam int LAT   = SIZE + H * SIZE + H + 1;  // LOAD entry to PO_VALID

  logic             CLK = 0;
  logic             nRST = 1;
  logic [WIDTH-1:0] PI = '0;
  logic             PI_VALID = 0;
  logic             PI_READY;
  logic [WIDTH-1:0] PO;
  logic             PO_VALID;
  logic             PO_READY = 0;
  logic [WIDTH-1:0] MED_DI;
  logic             MED_DSI;
  logic             MED_BYP;
  logic [WIDTH-1:0] MED_DO = '0;
  logic             BUSY;

  always #5 CLK = ~CLK;

  med_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .PI(PI), .PI_VALID(PI_VALID), .PI_READY(PI_READY),
    .PO(PO), .PO_VALID(PO_VALID), .PO_READY(PO_READY),
    .MED_DI(MED_DI), .MED_DSI(MED_DSI), .MED_BYP(MED_BYP), .MED_DO(MED_DO),
    .BUSY(BUSY)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
  endtask

  function automatic int median(input int w[$]);
    int a[SIZE];
    int t;
    for (int i = 0; i < SIZE; i++) a[i] = w[i];
    for (int i = 1; i < SIZE; i++)
      for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
        t = a[j]; a[j] = a[j-1]; a[j-1] = t;
      end
    return a[H];
  endfunction

  // stimulus / model state
  int pix_q[$], cur_win[$], exp_q[$];
  int pv_pct = 100, pr_pct = 100;
  bit pv_alt = 0;
  int cyc = 0, mb = 0, load_start = 0, dsi_run = 0, consume_cyc = 0;
  bit in_run = 0, prev_dsi = 0, prev_pov = 0, chk_consume = 0;
  int last_po = -1, n_po = 0;
  // MED stand-in
  int lst[$];
  int run = 0, rem = 0;

  task automatic model_reset();
    pix_q.delete(); cur_win.delete(); exp_q.delete(); lst.delete();
    mb = 0; in_run = 0; prev_dsi = 0; prev_pov = 0; run = 0; rem = 0;
    MED_DO = '0; PI_VALID = 0;
  endtask

  task automatic monitor();
    int mx, mi, v;
    if (MED_DSI && !prev_dsi) begin
      in_run = 1; load_start = cyc; dsi_run = 0;
      chk("load_full", mb, SIZE);
    end
    if (MED_DSI) dsi_run++;
    if (!MED_DSI && prev_dsi) chk("dsi_len", dsi_run, SIZE);
    if (PO_VALID && !prev_pov) begin
      chk("latency", cyc - load_start, LAT);
      in_run = 0;
      if (chk_consume) begin
        chk("restart_lat", cyc - consume_cyc, LAT + 2);
        chk_consume = 0;
      end
    end
    chk("busy", BUSY, in_run);
    chk("pi_ready", PI_READY, (mb < SIZE) && !MED_DSI);
    if (!in_run) begin
      chk("idle_dsi", MED_DSI, 0);
      chk("idle_byp", MED_BYP, 1);
      chk("idle_di", MED_DI, 0);
    end
    // MED stand-in: effect of this cycle's drive at the coming edge
    if (MED_DSI) begin
      if (!prev_dsi) begin lst.delete(); rem = 0; end
      lst.push_back(int'(MED_DI));
      run = 0;
      if (dsi_run == SIZE) mb = 0;
    end else if (MED_BYP) begin
      if (run == SIZE - 1 && rem < H && lst.size() > 0) begin
        mx = -1; mi = 0;
        foreach (lst[i]) if (lst[i] > mx) begin mx = lst[i]; mi = i; end
        lst.delete(mi);
        rem++;
      end
      run = 0;
    end else begin
      run++;
    end
    mx = 0;
    foreach (lst[i]) if (lst[i] > mx) mx = lst[i];
    MED_DO = WIDTH'(mx);
    // stream transfers at the coming edge
    if (PI_VALID && PI_READY) begin
      v = pix_q.pop_front();
      cur_win.push_back(v);
      mb++;
      if (cur_win.size() == SIZE) begin
        exp_q.push_back(median(cur_win));
        cur_win.delete();
      end
    end
    if (PO_VALID && PO_READY) begin
      if (exp_q.size() == 0) chk("po_extra", 1, 0);
      else chk("po", PO, exp_q.pop_front());
      last_po = int'(PO); n_po++;
      consume_cyc = cyc;
    end
    prev_dsi = MED_DSI;
    prev_pov = PO_VALID;
  endtask

  // driver + monitor: drive on the falling edge, observe 1 time unit later
  initial forever begin
    @(negedge CLK);
    cyc++;
    if (nRST) begin
      PI_VALID = (pix_q.size() > 0) &&
                 (pv_alt ? (cyc % 2 == 0) : ($urandom_range(99) < pv_pct));
      if (pix_q.size() > 0) PI = WIDTH'(pix_q[0]);
      PO_READY = ($urandom_range(99) < pr_pct);
      #1;
      if (nRST) monitor();
    end
  end

  task automatic push_win(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    pix_q.push_back(a0); pix_q.push_back(a1); pix_q.push_back(a2);
    pix_q.push_back(a3); pix_q.push_back(a4); pix_q.push_back(a5);
    pix_q.push_back(a6); pix_q.push_back(a7); pix_q.push_back(a8);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((pix_q.size() > 0 || exp_q.size() > 0 || cur_win.size() > 0 || in_run) && n < budget) begin
      @(negedge CLK); n++;
    end
    #2;
    chk("drain_in_budget", n < budget, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_po"}, PO, 0);
    chk({tag, "_pov"}, PO_VALID, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_pirdy"}, PI_READY, 1);
    chk({tag, "_dsi"}, MED_DSI, 0);
    chk({tag, "_byp"}, MED_BYP, 1);
    chk({tag, "_di"}, MED_DI, 0);
  endtask

  initial begin
    int held, bad, n;
    bit seen;

    // power-on reset
    #1 nRST = 0;
    #1 check_reset_outputs("rst");
    @(negedge CLK); #3 nRST = 1;

    // directed windows, no stalls
    push_win(9, 8, 7, 6, 5, 4, 3, 2, 1);
    wait_drain(300);
    chk("w_desc", last_po, 5);
    push_win(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    wait_drain(300);
    chk("w_const", last_po, 8'h7F);
    push_win(0, 255, 0, 255, 0, 255, 0, 255, 128);
    wait_drain(300);
    chk("w_alt", last_po, 128);

    // PI_VALID every other cycle during fill
    pv_alt = 1;
    push_win(20, 10, 30, 50, 40, 90, 70, 60, 80);
    wait_drain(400);
    chk("w_toggle", last_po, 50);
    pv_alt = 0;

    // output stalled for 200 cycles with two windows supplied
    pr_pct = 0;
    push_win(1, 2, 3, 4, 5, 6, 7, 8, 9);
    push_win(200, 100, 150, 50, 250, 0, 25, 75, 175);
    seen = 0; held = 0; bad = 0;
    repeat (200) begin
      @(negedge CLK); #2;
      if (PO_VALID) begin
        if (!seen) begin held = int'(PO); seen = 1; end
        else if (int'(PO) != held || MED_DSI) bad++;
      end
    end
    chk("stall_pov", PO_VALID, 1);
    chk("stall_po", PO, 5);
    chk("stall_stable", bad, 0);
    chk("stall_pirdy", PI_READY, 0);
    chk("stall_idle", BUSY, 0);
    chk("stall_pending", exp_q.size(), 2);
    chk_consume = 1;
    pr_pct = 100;
    wait_drain(400);
    chk("stall_second", last_po, 100);

    // reset in the middle of a run
    push_win(3, 1, 4, 1, 5, 9, 2, 6, 5);
    n = 0;
    while (!in_run && n < 200) begin @(negedge CLK); n++; end
    chk("mid_run_start", in_run, 1);
    n = 0;
    while (cyc < load_start + 20 && n < 200) begin @(negedge CLK); n++; end
    #3 nRST = 0;
    #1 check_reset_outputs("abort");
    model_reset();
    repeat (2) @(negedge CLK);
    #3 nRST = 1;
    repeat (60) @(negedge CLK);
    #2 chk("abort_no_po", PO_VALID, 0);
    push_win(1, 2, 3, 4, 5, 6, 7, 8, 9);
    wait_drain(300);
    chk("abort_fresh", last_po, 5);

    // random windows with stalls on both streams
    pv_pct = 80; pr_pct = 80;
    n_po = 0;
    for (int w = 0; w < 1000; w++)
      for (int i = 0; i < SIZE; i++) pix_q.push_back(int'($urandom_range(255)));
    wait_drain(80000);
    chk("rand_count", n_po, 1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
